// File: rtl/ahb_sram_slave.sv
// AHB SRAM slave with byte-lane writes, two-cycle ERROR responses and an exclusive-access monitor.
// Optional feature macro: AHB_SRAM_WAIT_EN inserts WAIT_CYCLES wait states before every legal data phase.
module ahb_sram_slave #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_BYTES   = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  hclk,
  input  logic                  hresetn,
  input  logic                  hsel,
  input  logic [ADDR_WIDTH-1:0] haddr,
  input  logic [2:0]            hburst,
  input  logic                  hmastlock,
  input  logic [6:0]            hprot,
  input  logic [2:0]            hsize,
  input  logic                  hnonsec,
  input  logic                  hexcl,
  input  logic [3:0]            hmaster,
  input  logic [1:0]            htrans,
  input  logic [DATA_WIDTH-1:0] hwdata,
  input  logic                  hwrite,
  output logic [DATA_WIDTH-1:0] hrdata,
  output logic                  hready,
  output logic                  hresp,
  output logic                  hexokay
);
  localparam int NB        = DATA_WIDTH / 8;
  localparam int LANE_BITS = $clog2(NB);
  localparam int BYTE_AW   = $clog2(MEM_BYTES);
  localparam int WORD_AW   = BYTE_AW - LANE_BITS;
  localparam int WORDS     = MEM_BYTES / NB;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_ERR1 = 3'd3;
  localparam logic [2:0] S_ERR2 = 3'd4;

  logic [2:0]            r_state;
  logic [BYTE_AW-1:0]    r_addr;
  logic [2:0]            r_size;
  logic                  r_write;
  logic                  r_excl;
  logic [3:0]            r_master;
  logic                  r_resValid;
  logic [3:0]            r_resMaster;
  logic [WORD_AW-1:0]    r_resWord;
  logic [DATA_WIDTH-1:0] r_mem [WORDS];

  logic                  w_accept;
  logic                  w_legal;
  logic [ADDR_WIDTH-1:0] w_alignMask;
  logic                  w_complete;
  logic [WORD_AW-1:0]    w_wordAddr;
  logic [LANE_BITS-1:0]  w_laneOff;
  logic                  w_resHit;
  logic                  w_exclWrOk;
  logic                  w_doWrite;
  logic                  w_waitDone;
  logic [NB-1:0]         w_byteEn;
  logic                  w_unused;

  assign w_unused = &{1'b0, hburst, hmastlock, hprot, hnonsec, WAIT_CYCLES[0]};

  // ERR2 drives hready high but always retires to IDLE, so only IDLE and DATA take a new address phase.
  assign w_accept    = hsel && htrans[1] && (r_state == S_IDLE || r_state == S_DATA);
  assign w_alignMask = (ADDR_WIDTH'(1) << hsize) - ADDR_WIDTH'(1);
  assign w_legal     = !(|(haddr >> BYTE_AW)) && (hsize <= 3'(LANE_BITS)) && !(|(haddr & w_alignMask));

  assign w_complete = (r_state == S_DATA) && hresetn;
  assign w_wordAddr = r_addr[BYTE_AW-1:LANE_BITS];
  assign w_laneOff  = r_addr[LANE_BITS-1:0];
  assign w_resHit   = r_resValid && (r_resWord == w_wordAddr);
  assign w_exclWrOk = w_resHit && (r_resMaster == r_master);
  assign w_doWrite  = w_complete && r_write && (!r_excl || w_exclWrOk);

  always_comb begin
    w_byteEn = '0;
    for (int i = 0; i < NB; i++) begin
      w_byteEn[i] = (i >= int'(w_laneOff)) && (i < int'(w_laneOff) + (1 << r_size));
    end
  end

`ifdef AHB_SRAM_WAIT_EN
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
  logic [3:0] r_waitCnt;

  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      r_waitCnt <= '0;
    end else if (w_accept && w_legal) begin
      r_waitCnt <= WAIT_LOAD;
    end else if (r_state == S_WAIT && r_waitCnt != 4'd0) begin
      r_waitCnt <= r_waitCnt - 4'd1;
    end
  end

  assign w_waitDone = (r_waitCnt == 4'd0);
`else
  assign w_waitDone = 1'b1;
`endif

  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_size      <= '0;
      r_write     <= 1'b0;
      r_excl      <= 1'b0;
      r_master    <= '0;
      r_resValid  <= 1'b0;
      r_resMaster <= '0;
      r_resWord   <= '0;
    end else begin
      if (w_complete && r_excl && !r_write) begin
        r_resValid  <= 1'b1;
        r_resMaster <= r_master;
        r_resWord   <= w_wordAddr;
      end else if (w_doWrite && w_resHit) begin
        r_resValid <= 1'b0;
      end
      if (w_accept) begin
        r_addr   <= haddr[BYTE_AW-1:0];
        r_size   <= hsize;
        r_write  <= hwrite;
        r_excl   <= hexcl;
        r_master <= hmaster;
        if (!w_legal) begin
          r_state <= S_ERR1;
`ifdef AHB_SRAM_WAIT_EN
        end else if (WAIT_CYCLES > 0) begin
          r_state <= S_WAIT;
`endif
        end else begin
          r_state <= S_DATA;
        end
      end else begin
        case (r_state)
          S_WAIT:  r_state <= w_waitDone ? S_DATA : S_WAIT;
          S_ERR1:  r_state <= S_ERR2;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  // Storage has no reset; a reset edge suppresses any write still in its data phase.
  always_ff @(posedge hclk) begin
    if (w_doWrite) begin
      for (int i = 0; i < NB; i++) begin
        if (w_byteEn[i]) r_mem[w_wordAddr][8*i +: 8] <= hwdata[8*i +: 8];
      end
    end
  end

  assign hready  = !(r_state == S_WAIT || r_state == S_ERR1);
  assign hresp   = (r_state == S_ERR1) || (r_state == S_ERR2);
  assign hexokay = (r_state == S_DATA) && r_excl && (!r_write || w_exclWrOk);
  assign hrdata  = (r_state == S_DATA && !r_write) ? r_mem[w_wordAddr] : '0;
endmodule

// File: tb/tb_ahb_sram_slave.sv
// Randomized bench for ahb_sram_slave: a byte-addressed memory/reservation model predicts every response cycle.
module tb_ahb_sram_slave;
  localparam int MEM_BYTES   = 1024;
  localparam int WAIT_CYCLES = 2;
`ifdef AHB_SRAM_WAIT_EN
  localparam int EXP_WAITS = WAIT_CYCLES;
`else
  localparam int EXP_WAITS = 0;
`endif

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [2:0]  size;
    logic        excl;
    logic [3:0]  master;
    logic [31:0] data;
  } xfer_t;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic        hsel;
  logic [31:0] haddr;
  logic [2:0]  hburst;
  logic        hmastlock;
  logic [6:0]  hprot;
  logic [2:0]  hsize;
  logic        hnonsec;
  logic        hexcl;
  logic [3:0]  hmaster;
  logic [1:0]  htrans;
  logic [31:0] hwdata;
  logic        hwrite;
  logic [31:0] hrdata;
  logic        hready;
  logic        hresp;
  logic        hexokay;

  ahb_sram_slave #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_BYTES(MEM_BYTES), .WAIT_CYCLES(WAIT_CYCLES)
  ) dut (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel), .haddr(haddr), .hburst(hburst),
    .hmastlock(hmastlock), .hprot(hprot), .hsize(hsize), .hnonsec(hnonsec), .hexcl(hexcl),
    .hmaster(hmaster), .htrans(htrans), .hwdata(hwdata), .hwrite(hwrite),
    .hrdata(hrdata), .hready(hready), .hresp(hresp), .hexokay(hexokay)
  );

  always #5 hclk = ~hclk;

  int checks = 0;
  int failures = 0;
  int lowCount = 0;
  int respCount = 0;
  bit checkEn = 1'b0;
  bit dataPending = 1'b0;

  logic        expReady, expResp, expExok;
  logic [31:0] expData;
  logic [31:0] lastExpData, dutData;
  logic        lastExpExok, dutExok;

  // Reference model state: byte memory plus the single exclusive reservation.
  logic [7:0]  memModel [MEM_BYTES];
  bit          resValid = 1'b0;
  logic [3:0]  resMaster;
  logic [31:0] resWord;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge hclk) begin
    if (checkEn) begin
      checkOutput("hready", 32'(hready), 32'(expReady));
      checkOutput("hresp", 32'(hresp), 32'(expResp));
      checkOutput("hrdata", hrdata, expData);
      checkOutput("hexokay", 32'(hexokay), 32'(expExok));
      if (hready === 1'b0) lowCount++;
      if (hresp === 1'b1) respCount++;
    end
  end

  task automatic setExp(input logic rdy, input logic rsp, input logic [31:0] d, input logic ex);
    expReady = rdy; expResp = rsp; expData = d; expExok = ex;
  endtask

  function automatic bit isLegal(input logic [31:0] a, input logic [2:0] s);
    if (a >= MEM_BYTES) return 1'b0;
    if (s > 3'd2) return 1'b0;
    if ((a % (32'd1 << s)) != 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] modelWord(input logic [31:0] a);
    int base = int'(a / 4) * 4;
    return {memModel[base+3], memModel[base+2], memModel[base+1], memModel[base]};
  endfunction

  function automatic xfer_t mk(input logic w, input logic [31:0] a, input logic [2:0] s,
                               input logic e, input logic [3:0] m, input logic [31:0] d);
    xfer_t t;
    t.write = w; t.addr = a; t.size = s; t.excl = e; t.master = m; t.data = d;
    return t;
  endfunction

  task automatic driveIdle();
    hsel      = 1'($urandom_range(0, 1));
    htrans    = hsel ? 2'($urandom_range(0, 1)) : 2'($urandom_range(0, 3));
    haddr     = $urandom;
    hsize     = 3'($urandom_range(0, 7));
    hwrite    = 1'($urandom_range(0, 1));
    hexcl     = 1'($urandom_range(0, 1));
    hmaster   = 4'($urandom_range(0, 15));
    hburst    = 3'($urandom_range(0, 7));
    hmastlock = 1'($urandom_range(0, 1));
    hprot     = 7'($urandom_range(0, 127));
    hnonsec   = 1'($urandom_range(0, 1));
  endtask

  // Issue one transfer; with b2b set it returns inside the data phase so the next address overlaps it.
  task automatic applyStimulus(input xfer_t t, input bit b2b);
    logic [31:0] eData;
    logic        eExok;
    bit          ok;
    driveIdle();
    hsel = 1'b1; htrans = $urandom_range(0, 1) ? 2'b10 : 2'b11;
    haddr = t.addr; hsize = t.size; hwrite = t.write; hexcl = t.excl; hmaster = t.master;
    if (!dataPending) hwdata = $urandom;
    @(posedge hclk); #1;
    dataPending = 1'b0;
    driveIdle();
    hwdata = $urandom;
    if (!isLegal(t.addr, t.size)) begin
      setExp(1'b0, 1'b1, 32'd0, 1'b0);
      @(posedge hclk); #1;
      setExp(1'b1, 1'b1, 32'd0, 1'b0);
      @(posedge hclk); #1;
      setExp(1'b1, 1'b0, 32'd0, 1'b0);
      lastExpData = 32'd0; lastExpExok = 1'b0;
      return;
    end
    for (int w = 0; w < EXP_WAITS; w++) begin
      setExp(1'b0, 1'b0, 32'd0, 1'b0);
      @(posedge hclk); #1;
    end
    eData = 32'd0; eExok = 1'b0;
    if (t.write) begin
      ok = !t.excl || (resValid && resMaster == t.master && resWord == t.addr / 4);
      eExok = t.excl && ok;
      if (ok) begin
        for (int b = 0; b < (1 << t.size); b++)
          memModel[t.addr + b] = t.data[8 * ((t.addr + b) % 4) +: 8];
        if (resValid && resWord == t.addr / 4) resValid = 1'b0;
      end
      hwdata = t.data;
    end else begin
      eData = modelWord(t.addr);
      if (t.excl) begin
        eExok = 1'b1; resValid = 1'b1; resMaster = t.master; resWord = t.addr / 4;
      end
    end
    setExp(1'b1, 1'b0, eData, eExok);
    lastExpData = eData; lastExpExok = eExok;
    if (b2b) begin
      dataPending = 1'b1;
      return;
    end
    @(negedge hclk);
    dutData = hrdata; dutExok = hexokay;
    @(posedge hclk); #1;
    setExp(1'b1, 1'b0, 32'd0, 1'b0);
  endtask

  // Start a word write, then pull reset during its first response cycle so it never lands.
  task automatic resetMid(input logic [31:0] addr, input logic [31:0] data);
    driveIdle();
    hsel = 1'b1; htrans = 2'b10; haddr = addr; hsize = 3'd2; hwrite = 1'b1; hexcl = 1'b0;
    if (!dataPending) hwdata = $urandom;
    @(posedge hclk); #1;
    dataPending = 1'b0;
    driveIdle();
    hwdata = data; hresetn = 1'b0;
    setExp((EXP_WAITS > 0) ? 1'b0 : 1'b1, 1'b0, 32'd0, 1'b0);
    @(posedge hclk); #1;
    hresetn = 1'b1; resValid = 1'b0;
    setExp(1'b1, 1'b0, 32'd0, 1'b0);
  endtask

  function automatic xfer_t randXfer();
    xfer_t t;
    int k = $urandom_range(0, 15);
    int word = $urandom_range(0, 1) ? $urandom_range(0, 3) : $urandom_range(0, 31);
    t.write = 1'($urandom_range(0, 1));
    t.excl = ($urandom_range(0, 2) == 0);
    t.master = 4'($urandom_range(0, 3));
    t.data = $urandom;
    t.size = 3'($urandom_range(0, 2));
    t.addr = 32'(word * 4) + (32'($urandom_range(0, 3)) & ~((32'd1 << t.size) - 1));
    if (k == 0) t.addr = 32'(MEM_BYTES) + 32'($urandom_range(0, 4095));
    else if (k == 1) t.size = 3'($urandom_range(3, 7));
    else if (k == 2) begin
      t.size = 3'($urandom_range(1, 2));
      t.addr = 32'(word * 4) + 32'd1;
    end
    return t;
  endfunction

  initial begin
    int lowBefore, respBefore;
    xfer_t t;
    hresetn = 1'b0;
    hwdata = '0;
    driveIdle();
    repeat (2) @(posedge hclk);
    #1;
    setExp(1'b1, 1'b0, 32'd0, 1'b0);
    checkEn = 1'b1;
    @(posedge hclk); #1;
    hresetn = 1'b1;

    for (int w = 0; w < 32; w++)
      applyStimulus(mk(1'b1, 32'(w * 4), 3'd2, 1'b0, 4'd0, $urandom), bit'($urandom_range(0, 1)));

    applyStimulus(mk(1'b1, 32'h10, 3'd2, 1'b0, 4'd1, 32'hDEADBEEF), 1'b0);
    applyStimulus(mk(1'b0, 32'h10, 3'd2, 1'b0, 4'd1, 32'd0), 1'b0);
    checkOutput("rd_after_wr_dut", dutData, 32'hDEADBEEF);
    checkOutput("rd_after_wr_model", lastExpData, 32'hDEADBEEF);

    applyStimulus(mk(1'b1, 32'h20, 3'd2, 1'b0, 4'd2, 32'h12345678), 1'b0);
    lowBefore = lowCount;
    applyStimulus(mk(1'b0, 32'h20, 3'd2, 1'b0, 4'd2, 32'd0), 1'b0);
    checkOutput("wait_low_cycles", 32'(lowCount - lowBefore), 32'(EXP_WAITS));
    checkOutput("wait_read_data", dutData, 32'h12345678);

    applyStimulus(mk(1'b1, 32'h10, 3'd2, 1'b0, 4'd0, 32'h11223344), 1'b0);
    applyStimulus(mk(1'b1, 32'h13, 3'd0, 1'b0, 4'd0, 32'hAA556677), 1'b1);
    applyStimulus(mk(1'b0, 32'h10, 3'd2, 1'b0, 4'd0, 32'd0), 1'b0);
    checkOutput("byte_lane_dut", dutData, 32'hAA223344);
    checkOutput("byte_lane_model", lastExpData, 32'hAA223344);

    respBefore = respCount;
    applyStimulus(mk(1'b0, 32'(MEM_BYTES), 3'd2, 1'b0, 4'd0, 32'd0), 1'b0);
    applyStimulus(mk(1'b1, 32'h01, 3'd1, 1'b0, 4'd0, 32'hFFFFFFFF), 1'b0);
    checkOutput("error_resp_cycles", 32'(respCount - respBefore), 32'd4);
    applyStimulus(mk(1'b0, 32'h00, 3'd2, 1'b0, 4'd0, 32'd0), 1'b0);

    applyStimulus(mk(1'b0, 32'h40, 3'd2, 1'b1, 4'd3, 32'd0), 1'b0);
    checkOutput("excl_rd_okay", 32'(dutExok), 32'd1);
    applyStimulus(mk(1'b1, 32'h40, 3'd2, 1'b1, 4'd3, 32'h55), 1'b0);
    checkOutput("excl_wr_okay", 32'(dutExok), 32'd1);
    applyStimulus(mk(1'b0, 32'h40, 3'd2, 1'b0, 4'd3, 32'd0), 1'b0);
    checkOutput("excl_wr_data", dutData, 32'h55);
    applyStimulus(mk(1'b1, 32'h40, 3'd2, 1'b1, 4'd3, 32'h66), 1'b0);
    checkOutput("excl_rewr_fail", 32'(dutExok), 32'd0);
    applyStimulus(mk(1'b0, 32'h40, 3'd2, 1'b0, 4'd3, 32'd0), 1'b0);
    checkOutput("excl_rewr_data", dutData, 32'h55);

    applyStimulus(mk(1'b1, 32'h50, 3'd2, 1'b0, 4'd0, 32'h50505050), 1'b0);
    applyStimulus(mk(1'b0, 32'h60, 3'd2, 1'b1, 4'd1, 32'd0), 1'b0);
    resetMid(32'h50, 32'hCAFEF00D);
    applyStimulus(mk(1'b0, 32'h50, 3'd2, 1'b0, 4'd0, 32'd0), 1'b0);
    checkOutput("reset_abort_data", dutData, 32'h50505050);
    applyStimulus(mk(1'b1, 32'h60, 3'd2, 1'b1, 4'd1, 32'h77), 1'b0);
    checkOutput("reset_clears_resv", 32'(dutExok), 32'd0);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        resetMid(32'($urandom_range(0, 31) * 4), $urandom);
      end else begin
        t = randXfer();
        applyStimulus(t, (i != 399) && ($urandom_range(0, 1) == 1));
      end
    end
    if (dataPending) begin
      driveIdle();
      dataPending = 1'b0;
      @(posedge hclk); #1;
      setExp(1'b1, 1'b0, 32'd0, 1'b0);
    end
    repeat (2) @(posedge hclk);
    @(negedge hclk);
    #1;
    checkEn = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
